// File: rtl/axi_lite_arb_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter with independent round-robin
// write and read paths, one outstanding transaction per direction.
module axi_lite_arb_2to1 #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,

    input  logic [ADDR_W-1:0]   m0_AWADDR,
    input  logic                m0_AWVALID,
    output logic                m0_AWREADY,
    input  logic [DATA_W-1:0]   m0_WDATA,
    input  logic [DATA_W/8-1:0] m0_WSTRB,
    input  logic                m0_WVALID,
    output logic                m0_WREADY,
    output logic [1:0]          m0_BRESP,
    output logic                m0_BVALID,
    input  logic                m0_BREADY,
    input  logic [ADDR_W-1:0]   m0_ARADDR,
    input  logic                m0_ARVALID,
    output logic                m0_ARREADY,
    output logic [DATA_W-1:0]   m0_RDATA,
    output logic [1:0]          m0_RRESP,
    output logic                m0_RVALID,
    input  logic                m0_RREADY,

    input  logic [ADDR_W-1:0]   m1_AWADDR,
    input  logic                m1_AWVALID,
    output logic                m1_AWREADY,
    input  logic [DATA_W-1:0]   m1_WDATA,
    input  logic [DATA_W/8-1:0] m1_WSTRB,
    input  logic                m1_WVALID,
    output logic                m1_WREADY,
    output logic [1:0]          m1_BRESP,
    output logic                m1_BVALID,
    input  logic                m1_BREADY,
    input  logic [ADDR_W-1:0]   m1_ARADDR,
    input  logic                m1_ARVALID,
    output logic                m1_ARREADY,
    output logic [DATA_W-1:0]   m1_RDATA,
    output logic [1:0]          m1_RRESP,
    output logic                m1_RVALID,
    input  logic                m1_RREADY,

    output logic [ADDR_W-1:0]   s_AWADDR,
    output logic                s_AWVALID,
    input  logic                s_AWREADY,
    output logic [DATA_W-1:0]   s_WDATA,
    output logic [DATA_W/8-1:0] s_WSTRB,
    output logic                s_WVALID,
    input  logic                s_WREADY,
    input  logic [1:0]          s_BRESP,
    input  logic                s_BVALID,
    output logic                s_BREADY,
    output logic [ADDR_W-1:0]   s_ARADDR,
    output logic                s_ARVALID,
    input  logic                s_ARREADY,
    input  logic [DATA_W-1:0]   s_RDATA,
    input  logic [1:0]          s_RRESP,
    input  logic                s_RVALID,
    output logic                s_RREADY,

    output logic                w_busy,
    output logic                w_owner,
    output logic                r_busy,
    output logic                r_owner
);

    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;
    logic     w_own_q, w_own_nxt, last_w_q, last_w_nxt;
    logic     aw_done_q, aw_done_nxt, w_done_q, w_done_nxt;
    logic     r_own_q, r_own_nxt, last_r_q, last_r_nxt;

    // Granted-master views of the upstream inputs
    logic [ADDR_W-1:0] g_awaddr, g_araddr;
    logic [DATA_W-1:0] g_wdata;
    logic [STRB_W-1:0] g_wstrb;
    logic              g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;

    // Granted-master views of the upstream outputs, routed by owner
    logic              g_awready, g_wready, g_bvalid, g_arready, g_rvalid;
    logic [1:0]        g_bresp, g_rresp;
    logic [DATA_W-1:0] g_rdata;

    assign g_awaddr  = w_own_q ? m1_AWADDR  : m0_AWADDR;
    assign g_awvalid = w_own_q ? m1_AWVALID : m0_AWVALID;
    assign g_wdata   = w_own_q ? m1_WDATA   : m0_WDATA;
    assign g_wstrb   = w_own_q ? m1_WSTRB   : m0_WSTRB;
    assign g_wvalid  = w_own_q ? m1_WVALID  : m0_WVALID;
    assign g_bready  = w_own_q ? m1_BREADY  : m0_BREADY;
    assign g_araddr  = r_own_q ? m1_ARADDR  : m0_ARADDR;
    assign g_arvalid = r_own_q ? m1_ARVALID : m0_ARVALID;
    assign g_rready  = r_own_q ? m1_RREADY  : m0_RREADY;

    assign w_busy  = (w_state != W_IDLE);
    assign w_owner = w_own_q;
    assign r_busy  = (r_state != R_IDLE);
    assign r_owner = r_own_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state   <= W_IDLE;
            w_own_q   <= 1'b0;
            last_w_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            r_state   <= R_IDLE;
            r_own_q   <= 1'b0;
            last_r_q  <= 1'b1;
        end else begin
            w_state   <= w_state_nxt;
            w_own_q   <= w_own_nxt;
            last_w_q  <= last_w_nxt;
            aw_done_q <= aw_done_nxt;
            w_done_q  <= w_done_nxt;
            r_state   <= r_state_nxt;
            r_own_q   <= r_own_nxt;
            last_r_q  <= last_r_nxt;
        end
    end

    // Write path: grant, AW/W in either order, then B
    always_comb begin
        w_state_nxt = w_state;
        w_own_nxt   = w_own_q;
        last_w_nxt  = last_w_q;
        aw_done_nxt = aw_done_q;
        w_done_nxt  = w_done_q;
        s_AWADDR    = '0;
        s_AWVALID   = 1'b0;
        s_WDATA     = '0;
        s_WSTRB     = '0;
        s_WVALID    = 1'b0;
        s_BREADY    = 1'b0;
        g_awready   = 1'b0;
        g_wready    = 1'b0;
        g_bvalid    = 1'b0;
        g_bresp     = 2'b00;
        m0_AWREADY  = 1'b0;
        m0_WREADY   = 1'b0;
        m0_BVALID   = 1'b0;
        m0_BRESP    = 2'b00;
        m1_AWREADY  = 1'b0;
        m1_WREADY   = 1'b0;
        m1_BVALID   = 1'b0;
        m1_BRESP    = 2'b00;

        case (w_state)
            W_IDLE: begin
                if (m0_AWVALID || m1_AWVALID) begin
                    w_own_nxt   = (m0_AWVALID && m1_AWVALID) ? ~last_w_q : m1_AWVALID;
                    w_state_nxt = W_XFER;
                end
            end
            W_XFER: begin
                s_AWVALID   = g_awvalid & ~aw_done_q;
                s_WVALID    = g_wvalid & ~w_done_q;
                g_awready   = s_AWREADY & ~aw_done_q;
                g_wready    = s_WREADY & ~w_done_q;
                aw_done_nxt = aw_done_q | (g_awvalid & ~aw_done_q & s_AWREADY);
                w_done_nxt  = w_done_q | (g_wvalid & ~w_done_q & s_WREADY);
                if (aw_done_nxt && w_done_nxt) begin
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                g_bvalid = s_BVALID;
                g_bresp  = s_BRESP;
                s_BREADY = g_bready;
                if (s_BVALID && g_bready) begin
                    w_state_nxt = W_IDLE;
                    last_w_nxt  = w_own_q;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase

        if (w_state != W_IDLE) begin
            s_AWADDR = g_awaddr;
            s_WDATA  = g_wdata;
            s_WSTRB  = g_wstrb;
        end

        if (w_own_q) begin
            m1_AWREADY = g_awready;
            m1_WREADY  = g_wready;
            m1_BVALID  = g_bvalid;
            m1_BRESP   = g_bresp;
        end else begin
            m0_AWREADY = g_awready;
            m0_WREADY  = g_wready;
            m0_BVALID  = g_bvalid;
            m0_BRESP   = g_bresp;
        end
    end

    // Read path: grant, AR, then R
    always_comb begin
        r_state_nxt = r_state;
        r_own_nxt   = r_own_q;
        last_r_nxt  = last_r_q;
        s_ARADDR    = '0;
        s_ARVALID   = 1'b0;
        s_RREADY    = 1'b0;
        g_arready   = 1'b0;
        g_rvalid    = 1'b0;
        g_rdata     = '0;
        g_rresp     = 2'b00;
        m0_ARREADY  = 1'b0;
        m0_RVALID   = 1'b0;
        m0_RDATA    = '0;
        m0_RRESP    = 2'b00;
        m1_ARREADY  = 1'b0;
        m1_RVALID   = 1'b0;
        m1_RDATA    = '0;
        m1_RRESP    = 2'b00;

        case (r_state)
            R_IDLE: begin
                if (m0_ARVALID || m1_ARVALID) begin
                    r_own_nxt   = (m0_ARVALID && m1_ARVALID) ? ~last_r_q : m1_ARVALID;
                    r_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                s_ARVALID = g_arvalid;
                g_arready = s_ARREADY;
                if (g_arvalid && s_ARREADY) begin
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                g_rvalid = s_RVALID;
                g_rdata  = s_RDATA;
                g_rresp  = s_RRESP;
                s_RREADY = g_rready;
                if (s_RVALID && g_rready) begin
                    r_state_nxt = R_IDLE;
                    last_r_nxt  = r_own_q;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase

        if (r_state != R_IDLE) begin
            s_ARADDR = g_araddr;
        end

        if (r_own_q) begin
            m1_ARREADY = g_arready;
            m1_RVALID  = g_rvalid;
            m1_RDATA   = g_rdata;
            m1_RRESP   = g_rresp;
        end else begin
            m0_ARREADY = g_arready;
            m0_RVALID  = g_rvalid;
            m0_RDATA   = g_rdata;
            m0_RRESP   = g_rresp;
        end
    end

endmodule

// File: tb/tb_axi_lite_arb_2to1.sv
// Directed bench for axi_lite_arb_2to1: a table of single-master transactions
// plus hand-written sequences for ties, W-before-AW, concurrency, B stall and reset.
module tb_axi_lite_arb_2to1;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [31:0] m0_AWADDR, m1_AWADDR, m0_ARADDR, m1_ARADDR;
    logic        m0_AWVALID, m1_AWVALID, m0_AWREADY, m1_AWREADY;
    logic [31:0] m0_WDATA, m1_WDATA;
    logic [3:0]  m0_WSTRB, m1_WSTRB;
    logic        m0_WVALID, m1_WVALID, m0_WREADY, m1_WREADY;
    logic [1:0]  m0_BRESP, m1_BRESP;
    logic        m0_BVALID, m1_BVALID, m0_BREADY, m1_BREADY;
    logic        m0_ARVALID, m1_ARVALID, m0_ARREADY, m1_ARREADY;
    logic [31:0] m0_RDATA, m1_RDATA;
    logic [1:0]  m0_RRESP, m1_RRESP;
    logic        m0_RVALID, m1_RVALID, m0_RREADY, m1_RREADY;
    logic [31:0] s_AWADDR, s_WDATA, s_ARADDR, s_RDATA;
    logic [3:0]  s_WSTRB;
    logic        s_AWVALID, s_AWREADY, s_WVALID, s_WREADY;
    logic [1:0]  s_BRESP, s_RRESP;
    logic        s_BVALID, s_BREADY, s_ARVALID, s_ARREADY, s_RVALID, s_RREADY;
    logic        w_busy, w_owner, r_busy, r_owner;

    int n_cmp = 0;
    int n_bad = 0;
    int aw_cnt = 0;
    int w_cnt = 0;

    axi_lite_arb_2to1 #(.ADDR_W(32), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m0_AWADDR(m0_AWADDR), .m0_AWVALID(m0_AWVALID), .m0_AWREADY(m0_AWREADY),
        .m0_WDATA(m0_WDATA), .m0_WSTRB(m0_WSTRB), .m0_WVALID(m0_WVALID), .m0_WREADY(m0_WREADY),
        .m0_BRESP(m0_BRESP), .m0_BVALID(m0_BVALID), .m0_BREADY(m0_BREADY),
        .m0_ARADDR(m0_ARADDR), .m0_ARVALID(m0_ARVALID), .m0_ARREADY(m0_ARREADY),
        .m0_RDATA(m0_RDATA), .m0_RRESP(m0_RRESP), .m0_RVALID(m0_RVALID), .m0_RREADY(m0_RREADY),
        .m1_AWADDR(m1_AWADDR), .m1_AWVALID(m1_AWVALID), .m1_AWREADY(m1_AWREADY),
        .m1_WDATA(m1_WDATA), .m1_WSTRB(m1_WSTRB), .m1_WVALID(m1_WVALID), .m1_WREADY(m1_WREADY),
        .m1_BRESP(m1_BRESP), .m1_BVALID(m1_BVALID), .m1_BREADY(m1_BREADY),
        .m1_ARADDR(m1_ARADDR), .m1_ARVALID(m1_ARVALID), .m1_ARREADY(m1_ARREADY),
        .m1_RDATA(m1_RDATA), .m1_RRESP(m1_RRESP), .m1_RVALID(m1_RVALID), .m1_RREADY(m1_RREADY),
        .s_AWADDR(s_AWADDR), .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
        .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WVALID(s_WVALID), .s_WREADY(s_WREADY),
        .s_BRESP(s_BRESP), .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
        .s_ARADDR(s_ARADDR), .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
        .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
        .w_busy(w_busy), .w_owner(w_owner), .r_busy(r_busy), .r_owner(r_owner)
    );

    always #5 ACLK = ~ACLK;

    // Count downstream AW and W beats to catch duplicated or dropped handshakes
    always @(posedge ACLK) begin
        if (s_AWVALID && s_AWREADY) aw_cnt++;
        if (s_WVALID && s_WREADY) w_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          rd;
        bit          mst;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic        exp_owner;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_wr(input bit m, input logic v, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        if (m) begin
            m1_AWVALID = v; m1_WVALID = v; m1_AWADDR = a; m1_WDATA = d; m1_WSTRB = s;
        end else begin
            m0_AWVALID = v; m0_WVALID = v; m0_AWADDR = a; m0_WDATA = d; m0_WSTRB = s;
        end
    endtask

    task automatic set_rd(input bit m, input logic v, input logic [31:0] a);
        if (m) begin
            m1_ARVALID = v; m1_ARADDR = a;
        end else begin
            m0_ARVALID = v; m0_ARADDR = a;
        end
    endtask

    function automatic logic [31:0] awready_of(input bit m);
        return m ? 32'(m1_AWREADY) : 32'(m0_AWREADY);
    endfunction
    function automatic logic [31:0] bvalid_of(input bit m);
        return m ? 32'(m1_BVALID) : 32'(m0_BVALID);
    endfunction
    function automatic logic [31:0] bresp_of(input bit m);
        return m ? 32'(m1_BRESP) : 32'(m0_BRESP);
    endfunction
    function automatic logic [31:0] arready_of(input bit m);
        return m ? 32'(m1_ARREADY) : 32'(m0_ARREADY);
    endfunction
    function automatic logic [31:0] rvalid_of(input bit m);
        return m ? 32'(m1_RVALID) : 32'(m0_RVALID);
    endfunction
    function automatic logic [31:0] rdata_of(input bit m);
        return m ? m1_RDATA : m0_RDATA;
    endfunction
    function automatic logic [31:0] rresp_of(input bit m);
        return m ? 32'(m1_RRESP) : 32'(m0_RRESP);
    endfunction

    task automatic clear_inputs();
        set_wr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_wr(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        set_rd(1'b0, 1'b0, 32'h0);
        set_rd(1'b1, 1'b0, 32'h0);
        m0_BREADY = 1'b1; m1_BREADY = 1'b1; m0_RREADY = 1'b1; m1_RREADY = 1'b1;
        s_AWREADY = 1'b0; s_WREADY = 1'b0; s_ARREADY = 1'b0;
        s_BVALID = 1'b0; s_BRESP = 2'b00;
        s_RVALID = 1'b0; s_RDATA = 32'h0; s_RRESP = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        clear_inputs();
        ARESETn = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    // One isolated transaction against an always-ready slave: 3 cycles end to end
    task automatic run_vec(input vec_t v);
        @(negedge ACLK);
        s_AWREADY = 1'b1; s_WREADY = 1'b1; s_ARREADY = 1'b1;
        if (!v.rd) begin
            set_wr(v.mst, 1'b1, v.addr, v.data, v.strb);
            @(negedge ACLK);
            chk("tbl w_busy", 32'(w_busy), 1);
            chk("tbl w_owner", 32'(w_owner), 32'(v.exp_owner));
            chk("tbl s_AWVALID", 32'(s_AWVALID), 1);
            chk("tbl s_AWADDR", s_AWADDR, v.addr);
            chk("tbl s_WDATA", s_WDATA, v.data);
            chk("tbl s_WSTRB", 32'(s_WSTRB), 32'(v.strb));
            chk("tbl g_AWREADY", awready_of(v.mst), 1);
            chk("tbl other AWREADY", awready_of(~v.mst), 0);
            @(negedge ACLK);
            set_wr(v.mst, 1'b0, 32'h0, 32'h0, 4'h0);
            s_BVALID = 1'b1; s_BRESP = v.resp;
            #1;
            chk("tbl s_AWVALID in B", 32'(s_AWVALID), 0);
            chk("tbl BVALID", bvalid_of(v.mst), 1);
            chk("tbl BRESP", bresp_of(v.mst), 32'(v.exp_resp));
            @(negedge ACLK);
            chk("tbl w_busy done", 32'(w_busy), 0);
            s_BVALID = 1'b0; s_BRESP = 2'b00;
        end else begin
            set_rd(v.mst, 1'b1, v.addr);
            @(negedge ACLK);
            chk("tbl r_busy", 32'(r_busy), 1);
            chk("tbl r_owner", 32'(r_owner), 32'(v.exp_owner));
            chk("tbl s_ARVALID", 32'(s_ARVALID), 1);
            chk("tbl s_ARADDR", s_ARADDR, v.addr);
            chk("tbl g_ARREADY", arready_of(v.mst), 1);
            chk("tbl other ARREADY", arready_of(~v.mst), 0);
            @(negedge ACLK);
            set_rd(v.mst, 1'b0, 32'h0);
            s_RVALID = 1'b1; s_RDATA = v.data; s_RRESP = v.resp;
            #1;
            chk("tbl RVALID", rvalid_of(v.mst), 1);
            chk("tbl RDATA", rdata_of(v.mst), v.exp_data);
            chk("tbl RRESP", rresp_of(v.mst), 32'(v.exp_resp));
            chk("tbl other RDATA", rdata_of(~v.mst), 0);
            @(negedge ACLK);
            chk("tbl r_busy done", 32'(r_busy), 0);
            s_RVALID = 1'b0; s_RDATA = 32'h0; s_RRESP = 2'b00;
        end
    endtask

    initial begin
        vec_t vecs[5];
        int aw0, w0;
        vecs[0] = '{1'b0, 1'b0, 32'h10,       32'hDEADBEEF, 4'hF, 2'b00, 1'b0, 32'h0,        2'b00};
        vecs[1] = '{1'b0, 1'b1, 32'h20,       32'hCAFEF00D, 4'h3, 2'b10, 1'b1, 32'h0,        2'b10};
        vecs[2] = '{1'b1, 1'b0, 32'h4,        32'h12345678, 4'h0, 2'b10, 1'b0, 32'h12345678, 2'b10};
        vecs[3] = '{1'b1, 1'b1, 32'h8,        32'hA5A5A5A5, 4'h0, 2'b00, 1'b1, 32'hA5A5A5A5, 2'b00};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'h1, 2'b00, 1'b0, 32'h0,        2'b00};

        ARESETn = 1'b0;
        clear_inputs();
        #1;
        chk("rst w_busy", 32'(w_busy), 0);
        chk("rst r_busy", 32'(r_busy), 0);
        chk("rst w_owner", 32'(w_owner), 0);
        chk("rst r_owner", 32'(r_owner), 0);
        do_reset();
        #1;
        chk("rst s_AWVALID", 32'(s_AWVALID), 0);
        chk("rst s_ARVALID", 32'(s_ARVALID), 0);
        chk("rst s_BREADY", 32'(s_BREADY), 0);
        chk("rst s_RREADY", 32'(s_RREADY), 0);
        chk("rst s_AWADDR", s_AWADDR, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Three back-to-back ties: grants alternate m0, m1, m0
        do_reset();
        @(negedge ACLK);
        set_wr(1'b0, 1'b1, 32'h100, 32'h1111, 4'hF);
        set_wr(1'b1, 1'b1, 32'h200, 32'h2222, 4'hF);
        s_AWREADY = 1'b1; s_WREADY = 1'b1; s_BVALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bit e;
            e = (k == 1);
            @(negedge ACLK);
            chk("tie owner", 32'(w_owner), 32'(e));
            chk("tie winner AWREADY", awready_of(e), 1);
            chk("tie loser AWREADY", awready_of(~e), 0);
            chk("tie s_AWADDR", s_AWADDR, e ? 32'h200 : 32'h100);
            @(negedge ACLK);
            chk("tie winner BVALID", bvalid_of(e), 1);
            chk("tie loser BVALID", bvalid_of(~e), 0);
            @(negedge ACLK);
            chk("tie idle", 32'(w_busy), 0);
        end
        clear_inputs();

        // m1: W two cycles before AW, W accepted before AW
        do_reset();
        @(negedge ACLK);
        aw0 = aw_cnt; w0 = w_cnt;
        m1_WVALID = 1'b1; m1_WDATA = 32'h0BADF00D; m1_WSTRB = 4'hC;
        s_WREADY = 1'b1; s_AWREADY = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        chk("wfirst no grant", 32'(w_busy), 0);
        chk("wfirst s_WVALID idle", 32'(s_WVALID), 0);
        m1_AWVALID = 1'b1; m1_AWADDR = 32'h30;
        @(negedge ACLK);
        chk("wfirst owner", 32'(w_owner), 1);
        chk("wfirst s_WVALID", 32'(s_WVALID), 1);
        chk("wfirst AWREADY held", 32'(m1_AWREADY), 0);
        @(negedge ACLK);
        chk("wfirst w_done gates WVALID", 32'(s_WVALID), 0);
        chk("wfirst w_done gates WREADY", 32'(m1_WREADY), 0);
        chk("wfirst s_AWVALID", 32'(s_AWVALID), 1);
        chk("wfirst no B yet", 32'(s_BREADY), 0);
        m1_WVALID = 1'b0;
        s_AWREADY = 1'b1;
        #1;
        chk("wfirst AWREADY", 32'(m1_AWREADY), 1);
        @(negedge ACLK);
        m1_AWVALID = 1'b0;
        s_BVALID = 1'b1;
        #1;
        chk("wfirst BVALID", 32'(m1_BVALID), 1);
        @(negedge ACLK);
        s_BVALID = 1'b0;
        chk("wfirst idle", 32'(w_busy), 0);
        chk("wfirst AW count", 32'(aw_cnt - aw0), 1);
        chk("wfirst W count", 32'(w_cnt - w0), 1);

        // m1: AW and W accepted in the same cycle
        @(negedge ACLK);
        aw0 = aw_cnt; w0 = w_cnt;
        set_wr(1'b1, 1'b1, 32'h34, 32'h600DCAFE, 4'hF);
        @(negedge ACLK);
        chk("same owner", 32'(w_owner), 1);
        @(negedge ACLK);
        set_wr(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        s_BVALID = 1'b1;
        #1;
        chk("same BVALID", 32'(m1_BVALID), 1);
        @(negedge ACLK);
        s_BVALID = 1'b0;
        chk("same AW count", 32'(aw_cnt - aw0), 1);
        chk("same W count", 32'(w_cnt - w0), 1);
        clear_inputs();

        // Concurrent m0 read and m1 write
        do_reset();
        @(negedge ACLK);
        set_rd(1'b0, 1'b1, 32'h4);
        set_wr(1'b1, 1'b1, 32'h8, 32'h55AA55AA, 4'hF);
        s_ARREADY = 1'b1; s_AWREADY = 1'b1; s_WREADY = 1'b1;
        @(negedge ACLK);
        chk("conc r_owner", 32'(r_owner), 0);
        chk("conc w_owner", 32'(w_owner), 1);
        chk("conc s_ARADDR", s_ARADDR, 32'h4);
        chk("conc s_AWADDR", s_AWADDR, 32'h8);
        @(negedge ACLK);
        set_rd(1'b0, 1'b0, 32'h0);
        set_wr(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        s_RVALID = 1'b1; s_RDATA = 32'h12345678; s_RRESP = 2'b10;
        s_BVALID = 1'b1; s_BRESP = 2'b00;
        #1;
        chk("conc m0 RVALID", 32'(m0_RVALID), 1);
        chk("conc m0 RDATA", m0_RDATA, 32'h12345678);
        chk("conc m0 RRESP", 32'(m0_RRESP), 2);
        chk("conc m1 BVALID", 32'(m1_BVALID), 1);
        chk("conc m1 BRESP", 32'(m1_BRESP), 0);
        chk("conc m1 RVALID", 32'(m1_RVALID), 0);
        chk("conc m0 BVALID", 32'(m0_BVALID), 0);
        @(negedge ACLK);
        chk("conc r idle", 32'(r_busy), 0);
        chk("conc w idle", 32'(w_busy), 0);
        clear_inputs();

        // Slave stalls B for 5 cycles while m1 waits
        do_reset();
        @(negedge ACLK);
        set_wr(1'b0, 1'b1, 32'h40, 32'h40404040, 4'hF);
        s_AWREADY = 1'b1; s_WREADY = 1'b1;
        @(negedge ACLK);
        set_wr(1'b1, 1'b1, 32'h44, 32'h44444444, 4'hF);
        @(negedge ACLK);
        set_wr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            chk("stall w_busy", 32'(w_busy), 1);
            chk("stall owner", 32'(w_owner), 0);
            chk("stall m1 AWREADY", 32'(m1_AWREADY), 0);
            @(negedge ACLK);
        end
        s_BVALID = 1'b1;
        #1;
        chk("stall m0 BVALID", 32'(m0_BVALID), 1);
        @(negedge ACLK);
        s_BVALID = 1'b0;
        chk("stall idle gap", 32'(w_busy), 0);
        @(negedge ACLK);
        chk("stall m1 granted", 32'(w_owner), 1);
        chk("stall m1 busy", 32'(w_busy), 1);
        chk("stall m1 s_AWADDR", s_AWADDR, 32'h44);
        @(negedge ACLK);
        set_wr(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        s_BVALID = 1'b1;
        @(negedge ACLK);
        clear_inputs();

        // Reset asserted while in W_RESP
        do_reset();
        @(negedge ACLK);
        set_wr(1'b1, 1'b1, 32'h50, 32'h50505050, 4'hF);
        s_AWREADY = 1'b1; s_WREADY = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        set_wr(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        m1_BREADY = 1'b0;
        s_BVALID = 1'b1; s_BRESP = 2'b10;
        #1;
        chk("rmid BVALID before", 32'(m1_BVALID), 1);
        #1;
        ARESETn = 1'b0;
        m1_BREADY = 1'b1;
        #1;
        chk("rmid w_busy", 32'(w_busy), 0);
        chk("rmid w_owner", 32'(w_owner), 0);
        chk("rmid m1 BVALID", 32'(m1_BVALID), 0);
        chk("rmid m1 BRESP", 32'(m1_BRESP), 0);
        chk("rmid s_BREADY", 32'(s_BREADY), 0);
        @(negedge ACLK);
        chk("rmid no late B", 32'(m1_BVALID), 0);
        ARESETn = 1'b1;
        set_wr(1'b0, 1'b1, 32'h60, 32'h6, 4'hF);
        set_wr(1'b1, 1'b1, 32'h64, 32'h7, 4'hF);
        s_AWREADY = 1'b0;
        @(negedge ACLK);
        chk("rmid tie owner", 32'(w_owner), 0);
        chk("rmid tie busy", 32'(w_busy), 1);
        chk("rmid tie no B", 32'(m1_BVALID), 0);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_arb_2to1.md
# axi_lite_arb_2to1

Two-master to one-slave AXI4-Lite arbiter. Connects two upstream AXI4-Lite masters (m0_, m1_) to one downstream AXI4-Lite slave (s_). Write and read paths are arbitrated independently, each with round-robin priority and one outstanding transaction per direction. It sits between the test/CPU-side masters and the shared register slave, and is the single point that serializes access to that slave.

## Interface
- ADDR_W, 32, address width on all AW/AR channels
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports (mX_ = m0_ and m1_, each a separate port set; the block is slave on mX_ and master on s_):
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- mX_AWADDR in ADDR_W; mX_AWVALID in 1; mX_AWREADY out 1  upstream write address
- mX_WDATA in DATA_W; mX_WSTRB in DATA_W/8; mX_WVALID in 1; mX_WREADY out 1  upstream write data
- mX_BRESP out 2; mX_BVALID out 1; mX_BREADY in 1  upstream write response
- mX_ARADDR in ADDR_W; mX_ARVALID in 1; mX_ARREADY out 1  upstream read address
- mX_RDATA out DATA_W; mX_RRESP out 2; mX_RVALID out 1; mX_RREADY in 1  upstream read data
- s_AWADDR out ADDR_W; s_AWVALID out 1; s_AWREADY in 1  downstream write address
- s_WDATA out DATA_W; s_WSTRB out DATA_W/8; s_WVALID out 1; s_WREADY in 1  downstream write data
- s_BRESP in 2; s_BVALID in 1; s_BREADY out 1  downstream write response
- s_ARADDR out ADDR_W; s_ARVALID out 1; s_ARREADY in 1  downstream read address
- s_RDATA in DATA_W; s_RRESP in 2; s_RVALID in 1; s_RREADY out 1  downstream read data
- w_busy out 1, w_owner out 1; r_busy out 1, r_owner out 1  grant status (owner 0 = m0, 1 = m1)

## Operation
- Write FSM W_IDLE -> W_XFER -> W_RESP -> W_IDLE. Read FSM R_IDLE -> R_ADDR -> R_DATA -> R_IDLE. The two FSMs are fully independent.
- Grant request is mX_AWVALID (write) or mX_ARVALID (read). WVALID does not request a grant.
- Round robin: if both masters request in IDLE, grant goes to the master that is not last_w / last_r. A single requester always wins. last_w and last_r reset to 1, so m0 wins the first tie.
- W_XFER:
  - s_AWVALID = g_AWVALID & ~aw_done; s_WVALID = g_WVALID & ~w_done (g_ = granted master).
  - g_AWREADY / g_WREADY pass s_AWREADY / s_WREADY through combinationally, gated by ~aw_done / ~w_done.
  - aw_done and w_done set on their handshakes, in either order or in the same cycle.
  - Move to W_RESP in the cycle both are complete.
- W_RESP: g_BVALID = s_BVALID; g_BRESP = s_BRESP; s_BREADY = g_BREADY. On the B handshake: go to W_IDLE, last_w = owner, clear done flags.
- R_ADDR: s_ARVALID = g_ARVALID; g_ARREADY = s_ARREADY. On handshake go to R_DATA.
- R_DATA: g_RVALID/RDATA/RRESP = s_*; s_RREADY = g_RREADY. On handshake: go to R_IDLE, last_r = owner.
- Non-granted master, and both masters when the path is idle: READY = 0, VALID = 0, RDATA = 0, RESP = 2'b00. Its requests stay pending, never dropped.
- s_ address/data/strobe outputs are driven from the granted master while busy and are 0 when idle.
- Responses (OKAY/SLVERR) pass through unmodified. The block never generates a response itself.

## Timing
- Reset (async assert, sync-to-ACLK deassert use): FSMs idle, busy = 0, owner = 0, last_w = last_r = 1. Every output is 0.
- Grant latency 1 cycle: mX_AWVALID/ARVALID high in IDLE at edge N gives busy = 1 and owner valid after edge N, with s_AWVALID/ARVALID asserted in cycle N+1.
- Minimum write: 1 grant cycle + 1 AW/W cycle + 1 B cycle = 3 cycles. Minimum read: 3 cycles (grant, AR, R).
- Return to IDLE costs 1 cycle, so back-to-back transactions run 1 cycle apart and the next grant follows the round-robin rule.
- Upstream VALID dropping before handshake is illegal AXI. The block must not latch it; it forwards the signal as-is.
- Reset mid-transaction aborts everything: outputs are 0 immediately and no response is forwarded afterward.

## Test plan
- m0 writes 0xDEADBEEF, strobe 0xF, to address 0x10; the slave returns OKAY. Expect s_AW/s_W carrying those values, m0_BVALID with BRESP = 00, w_owner = 0, and 3 cycles total.
- m0 and m1 both assert AWVALID in the same cycle, three times in a row. Expect grant order m0, m1, m0, and m1_AWREADY = 0 while m0 owns the path.
- Write from m1 with WVALID two cycles before AWVALID, then repeat with AW and W in the same cycle. Both must complete; slave sees exactly one AW and one W each time.
- Concurrent m0 read of 0x4 with m1 write of 0x8, slave returning RDATA 0x12345678 with SLVERR on the read. Both complete independently; m0 gets RRESP = 10 and m1 gets OKAY.
- Slave holds BVALID low for 5 cycles. Expect w_busy to stay high, with the other master's AWVALID held and then granted 1 cycle after the B handshake.
- Assert ARESETn = 0 during W_RESP. Expect all outputs to go 0 asynchronously, and the first post-reset tie to go to m0.
